// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one port of the dual-port memory among NREQ
// requesters, with a tagged two-stage read-return pipeline.
module mem_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 3,
  parameter int NREQ  = 4
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [NREQ-1:0]                           i_req,
  input  logic [NREQ-1:0]                           i_we,
  input  logic [NREQ*ADDR-1:0]                      i_addr,
  input  logic [NREQ*WIDTH-1:0]                     i_wdata,
  input  logic                                      i_hold,
  output logic [NREQ-1:0]                           o_gnt,
  output logic                                      o_mem_en,
  output logic                                      o_mem_we,
  output logic [ADDR-1:0]                           o_mem_addr,
  output logic [WIDTH-1:0]                          o_mem_din,
  input  logic [WIDTH-1:0]                          i_mem_dout,
  output logic                                      o_rvalid,
  output logic [WIDTH-1:0]                          o_rdata,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] o_rid
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             s1Valid_q, s1Valid_d;
  logic [IDW-1:0]   s1Id_q, s1Id_d;
  logic             s2Valid_q, s2Valid_d;
  logic [IDW-1:0]   s2Id_q, s2Id_d;
  logic             memEn_q, memEn_d;
  logic             memWe_q, memWe_d;
  logic [ADDR-1:0]  memAddr_q, memAddr_d;
  logic [WIDTH-1:0] memDin_q, memDin_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [IDW-1:0]   rid_q, rid_d;

  logic [IDW-1:0]   win;
  logic             anyReq;
  logic             grantEn;
  logic [IDW:0]     scanIdx;
  logic [IDW:0]     ptrInc;
  logic [NREQ-1:0]  oneHot;

  // Scan from ptr upward with wrap-around; the first requester found wins.
  always_comb begin
    win     = ptr_q;
    anyReq  = 1'b0;
    scanIdx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scanIdx = {1'b0, ptr_q} + (IDW+1)'(i);
      if (scanIdx >= (IDW+1)'(NREQ)) scanIdx = scanIdx - (IDW+1)'(NREQ);
      if (!anyReq && i_req[scanIdx[IDW-1:0]]) begin
        anyReq = 1'b1;
        win    = scanIdx[IDW-1:0];
      end
    end
  end

  assign grantEn = i_rst_n & ~i_hold & anyReq;
  assign oneHot  = {{(NREQ-1){1'b0}}, 1'b1};
  assign o_gnt   = grantEn ? (oneHot << win) : '0;

  always_comb begin
    ptr_d     = ptr_q;
    ptrInc    = {1'b0, win} + 1'b1;
    memEn_d   = grantEn;
    memWe_d   = grantEn & i_we[win];
    memAddr_d = memAddr_q;
    memDin_d  = memDin_q;
    if (grantEn) begin
      ptr_d     = (ptrInc == (IDW+1)'(NREQ)) ? '0 : ptrInc[IDW-1:0];
      memAddr_d = i_addr[win*ADDR +: ADDR];
      memDin_d  = i_wdata[win*WIDTH +: WIDTH];
    end
    // Reads carry their requester id down the pipe to tag the returning data.
    s1Valid_d = grantEn & ~i_we[win];
    s1Id_d    = win;
    s2Valid_d = s1Valid_q;
    s2Id_d    = s1Id_q;
    rvalid_d  = s2Valid_q;
    rdata_d   = s2Valid_q ? i_mem_dout : rdata_q;
    rid_d     = s2Valid_q ? s2Id_q : rid_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q     <= '0;
      s1Valid_q <= 1'b0;
      s1Id_q    <= '0;
      s2Valid_q <= 1'b0;
      s2Id_q    <= '0;
      memEn_q   <= 1'b0;
      memWe_q   <= 1'b0;
      memAddr_q <= '0;
      memDin_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      s1Valid_q <= s1Valid_d;
      s1Id_q    <= s1Id_d;
      s2Valid_q <= s2Valid_d;
      s2Id_q    <= s2Id_d;
      memEn_q   <= memEn_d;
      memWe_q   <= memWe_d;
      memAddr_q <= memAddr_d;
      memDin_q  <= memDin_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
    end
  end

  assign o_mem_en   = memEn_q;
  assign o_mem_we   = memWe_q;
  assign o_mem_addr = memAddr_q;
  assign o_mem_din  = memDin_q;
  assign o_rvalid   = rvalid_q;
  assign o_rdata    = rdata_q;
  assign o_rid      = rid_q;

endmodule
